// File: rtl/snes_pkg.sv
// Shared SNES pad definitions: FSM states, button bit positions, word widths
// and the word decode used by both the console-side reader and the encoder.
package snes_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    GAP   = 3'd2,
    LOW   = 3'd3,
    HIGH  = 3'd4
  } snes_state_e;

  localparam int SNES_WORD_BITS = 16;
  localparam int SNES_BTN_BITS  = 12;
  localparam int SNES_ID_BITS   = SNES_WORD_BITS - SNES_BTN_BITS;

  // Bit positions within the decoded button vector (same order as on the wire)
  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

  // A genuine pad drives its trailing ID bits high; an unplugged or
  // foreign device usually pulls them low.
  function automatic logic snes_id_ok(input logic [SNES_WORD_BITS-1:0] raw);
    return raw[SNES_WORD_BITS-1:SNES_BTN_BITS] == {SNES_ID_BITS{1'b1}};
  endfunction

  // Wire level is active-low; the decoded vector is active-high.
  function automatic logic [SNES_BTN_BITS-1:0] snes_decode(input logic [SNES_WORD_BITS-1:0] raw);
    return ~raw[SNES_BTN_BITS-1:0];
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input. Resets to the
// "released" level so a pad line reads as idle until real data arrives.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic srst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Double-register the asynchronous input
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/snes_controller_reader.sv
// Console-side SNES pad poller. Generates latch and serial clock toward a
// physical pad, shifts in its 16-bit word (one bit per falling clock edge),
// checks the ID nibble and publishes 12 active-high buttons.
module snes_controller_reader
  import snes_pkg::*;
#(
  parameter int LATCH_CYC    = 25,
  parameter int HALF_BIT_CYC = 12,
  parameter int POLL_CYC     = 34667
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     poll_req,
  input  logic                     snes_data,
  output logic                     snes_latch,
  output logic                     snes_clk,
  output logic [SNES_BTN_BITS-1:0] buttons,
  output logic                     valid,
  output logic                     frame_err,
  output logic                     busy
);

  // Phase counter covers the longer of the latch pulse and a half bit.
  localparam int PH_MAX = (LATCH_CYC > HALF_BIT_CYC) ? LATCH_CYC : HALF_BIT_CYC;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int TMR_W  = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;

  localparam logic [PH_W-1:0]  LATCH_LAST = PH_W'(LATCH_CYC - 1);
  localparam logic [PH_W-1:0]  HALF_LAST  = PH_W'(HALF_BIT_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(POLL_CYC - 1);
  localparam logic [3:0]       LAST_BIT   = 4'(SNES_WORD_BITS - 1);

  snes_state_e               state_q,   state_d;
  logic [PH_W-1:0]           phase_q,   phase_d;
  logic [3:0]                bit_cnt_q, bit_cnt_d;
  logic [SNES_WORD_BITS-1:0] shift_q,   shift_d;
  logic [TMR_W-1:0]          timer_q,   timer_d;
  logic                      latch_q,   latch_d;
  logic                      sclk_q,    sclk_d;
  logic [SNES_BTN_BITS-1:0]  buttons_q, buttons_d;
  logic                      valid_q,   valid_d;
  logic                      ferr_q,    ferr_d;
  logic                      busy_q,    busy_d;

  logic data_sync;
  logic start_frame;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_data_sync (
    .clk_i (clock),
    .srst_i(reset),
    .d_i   (snes_data),
    .q_o   (data_sync)
  );

  // A frame may only start from IDLE; requests and expiries elsewhere are lost.
  assign start_frame = (state_q == IDLE) && ((timer_q == TMR_LAST) || poll_req);

  // Next-state, datapath and registered-output levels derived from next state
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    buttons_d = buttons_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    timer_d   = (timer_q == TMR_LAST) ? '0 : timer_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (start_frame) begin
          state_d   = LATCH;
          phase_d   = '0;
          bit_cnt_d = '0;
          timer_d   = '0;
        end
      end

      LATCH: begin
        if (phase_q == LATCH_LAST) begin
          state_d = GAP;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      GAP: begin
        if (phase_q == HALF_LAST) begin
          state_d = LOW;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      LOW: begin
        // Sample once, right after the falling edge; the pad shifted its
        // data half a bit earlier so the synchronized value is settled.
        if (phase_q == '0) begin
          shift_d[bit_cnt_q] = data_sync;
        end
        if (phase_q == HALF_LAST) begin
          state_d = HIGH;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      HIGH: begin
        if (phase_q == HALF_LAST) begin
          phase_d = '0;
          if (bit_cnt_q == LAST_BIT) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            if (snes_id_ok(shift_q)) begin
              buttons_d = snes_decode(shift_q);
              valid_d   = 1'b1;
            end else begin
              ferr_d    = 1'b1;
            end
          end else begin
            state_d   = LOW;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase

    latch_d = (state_d == LATCH);
    sclk_d  = (state_d != LOW);
    busy_d  = (state_d != IDLE);
  end

  // State and output registers; reset aborts any frame in progress
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '1;
      timer_q   <= TMR_LAST;
      latch_q   <= 1'b0;
      sclk_q    <= 1'b1;
      buttons_q <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      timer_q   <= timer_d;
      latch_q   <= latch_d;
      sclk_q    <= sclk_d;
      buttons_q <= buttons_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  assign snes_latch = latch_q;
  assign snes_clk   = sclk_q;
  assign buttons    = buttons_q;
  assign valid      = valid_q;
  assign frame_err  = ferr_q;
  assign busy       = busy_q;

endmodule
